// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer emitting start, LSB-first data, optional parity and stop bits,
// advancing one bit per baud_tick after a valid/ready accept that restarts the baud generator.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    output logic                 baud_restart,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state, w_state_n;
    logic [DATA_BITS-1:0] r_shreg, w_shreg_n;
    logic [IW-1:0]        r_bit_idx, w_bit_idx_n;
    logic                 r_stop_cnt, w_stop_cnt_n;
    logic                 r_par, w_par_n;
    logic                 r_tx, w_tx_n;
    logic                 r_done, w_done_n;
    logic                 w_accept;

    assign tx_ready     = (r_state == S_IDLE) && !rst;
    assign w_accept     = tx_valid && tx_ready;
    assign baud_restart = w_accept;
    assign tx           = r_tx;
    assign busy         = r_state != S_IDLE;
    assign done         = r_done;

    always_comb begin
        w_state_n    = r_state;
        w_shreg_n    = r_shreg;
        w_bit_idx_n  = r_bit_idx;
        w_stop_cnt_n = r_stop_cnt;
        w_par_n      = r_par;
        w_done_n     = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_n = S_START;
                w_shreg_n = tx_data;
                w_par_n   = (^tx_data) ^ (PARITY_ODD != 0);
            end
            S_START: if (baud_tick) begin
                w_state_n   = S_DATA;
                w_bit_idx_n = '0;
            end
            S_DATA: if (baud_tick) begin
                w_shreg_n = r_shreg >> 1;
                if (r_bit_idx == IW'(DATA_BITS - 1)) begin
                    w_state_n    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    w_stop_cnt_n = 1'b0;
                end else begin
                    w_bit_idx_n = r_bit_idx + IW'(1);
                end
            end
            S_PARITY: if (baud_tick) begin
                w_state_n    = S_STOP;
                w_stop_cnt_n = 1'b0;
            end
            S_STOP: if (baud_tick) begin
                if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                    w_state_n = S_IDLE;
                    w_done_n  = 1'b1;
                end else begin
                    w_stop_cnt_n = r_stop_cnt + 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        // tx is registered from the next state so each bit appears on the edge that enters it
        w_tx_n = (w_state_n == S_START)  ? 1'b0 :
                 (w_state_n == S_DATA)   ? w_shreg_n[0] :
                 (w_state_n == S_PARITY) ? w_par_n : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_shreg    <= w_shreg_n;
            r_bit_idx  <= w_bit_idx_n;
            r_stop_cnt <= w_stop_cnt_n;
            r_par      <= w_par_n;
            r_tx       <= w_tx_n;
            r_done     <= w_done_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed checks of four uart_tx_ctrl configurations (8N1, 8E1, 8O1, 8N2),
// each paired with a divide-by-16 baud generator restarted by the controller.
module tb_uart_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid = '0;
    logic [3:0] frc = '0;
    logic [3:0] tick, ready, restart, tx, busy, done;
    logic [7:0] data [4];
    logic [3:0] cnt [4];
    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        for (int k = 0; k < 4; k++) cnt[k] <= (rst || restart[k]) ? 4'd0 : cnt[k] + 4'd1;

    always_comb
        for (int k = 0; k < 4; k++) tick[k] = (cnt[k] == 4'd15) | frc[k];

    uart_tx_ctrl u0 (.clk(clk), .rst(rst), .baud_tick(tick[0]), .baud_restart(restart[0]),
        .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst(rst), .baud_tick(tick[1]), .baud_restart(restart[1]),
        .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .baud_tick(tick[2]), .baud_restart(restart[2]),
        .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));
    uart_tx_ctrl #(.STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .baud_tick(tick[3]), .baud_restart(restart[3]),
        .tx_data(data[3]), .tx_valid(valid[3]), .tx_ready(ready[3]), .tx(tx[3]), .busy(busy[3]), .done(done[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observes one frame starting at its accept edge; bit b occupies observations 1+16b..16+16b.
    task automatic capture(input int k, input int n, input logic bv, input logic [7:0] bd,
                           output logic [15:0] bits, output logic stable, output int done_at,
                           output int done_cnt, output int busy_bad, output int rs_cnt, output logic rs_at_done);
        bits = '0; stable = 1'b1; done_at = -1; done_cnt = 0; busy_bad = 0; rs_cnt = 0; rs_at_done = 1'b0;
        for (int c = 1; c <= 16 * n + 1; c++) begin
            step();
            if (c <= 16 * n) begin
                if ((c - 1) % 16 == 0) bits[(c - 1) / 16] = tx[k];
                else if (tx[k] !== bits[(c - 1) / 16]) stable = 1'b0;
                if (busy[k] !== 1'b1) busy_bad++;
                if (restart[k] !== 1'b0) rs_cnt++;
            end else begin
                rs_at_done = restart[k];
                if (busy[k] !== 1'b0) busy_bad++;
            end
            if (done[k] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == 1) begin
                valid[k] = bv;
                data[k]  = bd;
                frc[k]   = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 4'hF;
        for (int k = 0; k < 4; k++) data[k] = 8'hA5;
        repeat (3) step();
        total++; if (tx !== 4'hF) $display("FAIL reset_tx got=%h exp=f", tx); else pass++;
        total++; if (busy !== 4'h0) $display("FAIL reset_busy got=%h exp=0", busy); else pass++;
        total++; if (done !== 4'h0) $display("FAIL reset_done got=%h exp=0", done); else pass++;
        total++; if (ready !== 4'h0) $display("FAIL reset_ready got=%h exp=0", ready); else pass++;
        total++; if (restart !== 4'h0) $display("FAIL reset_restart got=%h exp=0", restart); else pass++;
        valid = 4'h0;
        rst = 1'b0;
        #1;
        total++; if (ready !== 4'hF) $display("FAIL ready_after_reset got=%h exp=f", ready); else pass++;
        step();
    endtask

    task automatic test_8n1();
        logic [15:0] b; logic st, rad; int da, dc, bb, rc;
        data[0] = 8'hA5; valid[0] = 1'b1;
        #1;
        total++; if (restart[0] !== 1'b1) $display("FAIL 8n1_restart got=%b exp=1", restart[0]); else pass++;
        capture(0, 10, 1'b0, 8'h00, b, st, da, dc, bb, rc, rad);
        total++; if (b[9:0] !== 10'b1_1010_0101_0) $display("FAIL 8n1_bits got=%b exp=%b", b[9:0], 10'b1_1010_0101_0); else pass++;
        total++; if (st !== 1'b1) $display("FAIL 8n1_stable got=%b exp=1", st); else pass++;
        total++; if (da != 161 || dc != 1) $display("FAIL 8n1_done at=%0d cnt=%0d exp at=161 cnt=1", da, dc); else pass++;
        total++; if (bb != 0 || rc != 0) $display("FAIL 8n1_busy busy_bad=%0d restarts=%0d exp 0/0", bb, rc); else pass++;
    endtask

    task automatic test_parity();
        logic [15:0] b; logic st, rad; int da, dc, bb, rc;
        data[1] = 8'h07; valid[1] = 1'b1;
        #1;
        total++; if (restart[1] !== 1'b1) $display("FAIL even_restart got=%b exp=1", restart[1]); else pass++;
        capture(1, 11, 1'b0, 8'h00, b, st, da, dc, bb, rc, rad);
        total++; if (b[10:0] !== 11'b1_1_0000_0111_0 || !st) $display("FAIL even_bits got=%b stable=%b exp=%b", b[10:0], st, 11'b1_1_0000_0111_0); else pass++;
        total++; if (da != 177 || dc != 1 || bb != 0) $display("FAIL even_done at=%0d cnt=%0d busy_bad=%0d exp 177/1/0", da, dc, bb); else pass++;
        data[2] = 8'h07; valid[2] = 1'b1;
        #1;
        capture(2, 11, 1'b0, 8'h00, b, st, da, dc, bb, rc, rad);
        total++; if (b[10:0] !== 11'b1_0_0000_0111_0 || !st) $display("FAIL odd_bits got=%b stable=%b exp=%b", b[10:0], st, 11'b1_0_0000_0111_0); else pass++;
        total++; if (da != 177 || dc != 1 || bb != 0) $display("FAIL odd_done at=%0d cnt=%0d busy_bad=%0d exp 177/1/0", da, dc, bb); else pass++;
    endtask

    task automatic test_two_stop();
        logic [15:0] b; logic st, rad; int da, dc, bb, rc;
        data[3] = 8'hFF; valid[3] = 1'b1;
        #1;
        capture(3, 11, 1'b0, 8'h00, b, st, da, dc, bb, rc, rad);
        total++; if (b[10:0] !== 11'b11_1111_1111_0 || !st) $display("FAIL stop2_bits got=%b stable=%b exp=%b", b[10:0], st, 11'b11_1111_1111_0); else pass++;
        total++; if (da != 177 || dc != 1 || bb != 0) $display("FAIL stop2_done at=%0d cnt=%0d busy_bad=%0d exp 177/1/0", da, dc, bb); else pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] b; logic st, rad; int da, dc, bb, rc;
        data[0] = 8'h12; valid[0] = 1'b1;
        #1;
        capture(0, 10, 1'b1, 8'h34, b, st, da, dc, bb, rc, rad);
        total++; if (b[9:0] !== 10'b1_0001_0010_0 || !st) $display("FAIL b2b_first got=%b stable=%b exp=%b", b[9:0], st, 10'b1_0001_0010_0); else pass++;
        total++; if (rad !== 1'b1 || da != 161) $display("FAIL b2b_accept_in_done restart=%b done_at=%0d exp 1/161", rad, da); else pass++;
        capture(0, 10, 1'b0, 8'h00, b, st, da, dc, bb, rc, rad);
        total++; if (b[9:0] !== 10'b1_0011_0100_0 || !st) $display("FAIL b2b_second got=%b stable=%b exp=%b", b[9:0], st, 10'b1_0011_0100_0); else pass++;
        total++; if (da != 161 || dc != 1) $display("FAIL b2b_second_done at=%0d cnt=%0d exp 161/1", da, dc); else pass++;
    endtask

    task automatic test_ignore_busy();
        logic [15:0] b; logic st, rad; int da, dc, bb, rc;
        data[0] = 8'h5A; valid[0] = 1'b1; frc[0] = 1'b1;
        #1;
        capture(0, 10, 1'b1, 8'hC3, b, st, da, dc, bb, rc, rad);
        total++; if (b[9:0] !== 10'b1_0101_1010_0 || !st) $display("FAIL busy_frame got=%b stable=%b exp=%b", b[9:0], st, 10'b1_0101_1010_0); else pass++;
        total++; if (rc != 0) $display("FAIL busy_no_accept restarts=%0d exp=0", rc); else pass++;
        total++; if (da != 161) $display("FAIL busy_tick_ignored done_at=%0d exp=161", da); else pass++;
        capture(0, 10, 1'b0, 8'h00, b, st, da, dc, bb, rc, rad);
        total++; if (b[9:0] !== 10'b1_1100_0011_0 || !st) $display("FAIL busy_next_frame got=%b stable=%b exp=%b", b[9:0], st, 10'b1_1100_0011_0); else pass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] b; logic st, rad; int da, dc, bb, rc;
        int dpulses = 0;
        data[0] = 8'h55; valid[0] = 1'b1;
        #1;
        step();
        valid[0] = 1'b0;
        repeat (69) step();
        total++; if (tx[0] !== 1'b0 || busy[0] !== 1'b1) $display("FAIL mid_data_bit3 tx=%b busy=%b exp 0/1", tx[0], busy[0]); else pass++;
        rst = 1'b1;
        step();
        total++; if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b0) $display("FAIL mid_reset tx=%b busy=%b ready=%b exp 1/0/0", tx[0], busy[0], ready[0]); else pass++;
        if (done[0] !== 1'b0) dpulses++;
        step();
        if (done[0] !== 1'b0) dpulses++;
        rst = 1'b0;
        #1;
        total++; if (ready[0] !== 1'b1) $display("FAIL mid_ready_after got=%b exp=1", ready[0]); else pass++;
        repeat (40) begin
            step();
            if (done[0] !== 1'b0) dpulses++;
        end
        total++; if (dpulses != 0) $display("FAIL mid_no_done pulses=%0d exp=0", dpulses); else pass++;
        data[0] = 8'h0F; valid[0] = 1'b1;
        #1;
        capture(0, 10, 1'b0, 8'h00, b, st, da, dc, bb, rc, rad);
        total++; if (b[9:0] !== 10'b1_0000_1111_0 || !st) $display("FAIL mid_next_frame got=%b stable=%b exp=%b", b[9:0], st, 10'b1_0000_1111_0); else pass++;
        total++; if (da != 161 || dc != 1) $display("FAIL mid_next_done at=%0d cnt=%0d exp 161/1", da, dc); else pass++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
